// File: rtl/edge_postproc.sv
// Post-processor after the convolution stage: absolute value, border blanking,
// optional thresholding, and a per-frame edge count. Two registered stages.
module edge_postproc #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int BORDER     = 1,
  parameter int CNT_W      = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iDVAL,
  input  logic [11:0]      iPIXEL,
  input  logic             iFRAME_START,
  input  logic [11:0]      iTHRESH,
  input  logic             iTHRESH_EN,
  output logic [11:0]      oRED,
  output logic [11:0]      oGREEN,
  output logic [11:0]      oBLUE,
  output logic             oDVAL,
  output logic             oFRAME_DONE,
  output logic [CNT_W-1:0] oEDGE_COUNT
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);

  logic [COL_W-1:0] col, cur_col;
  logic [ROW_W-1:0] row, cur_row;
  logic             col_wrap, row_wrap;
  logic             pix_mask, pix_last;
  logic [11:0]      pix_mag;

  logic             s1_valid, s1_mask, s1_last, s1_start, s1_thresh_en;
  logic [11:0]      s1_mag, s1_thresh;

  logic             s1_edge;
  logic [11:0]      s1_out;
  logic [CNT_W-1:0] run_count, run_base, run_next;
  logic [11:0]      rgb;

  // A frame-start pixel is placed at (0,0) regardless of where the counters were.
  always_comb begin
    cur_col  = iFRAME_START ? '0 : col;
    cur_row  = iFRAME_START ? '0 : row;
    col_wrap = (cur_col == COL_W'(IMG_WIDTH - 1));
    row_wrap = (cur_row == ROW_W'(IMG_HEIGHT - 1));
    pix_last = col_wrap && row_wrap && !iFRAME_START;
    pix_mask = (int'(cur_col) < BORDER) || (int'(cur_col) >= IMG_WIDTH - BORDER) ||
               (int'(cur_row) < BORDER) || (int'(cur_row) >= IMG_HEIGHT - BORDER);
    if (iPIXEL == 12'h800)
      pix_mag = 12'h7FF;
    else if (iPIXEL[11])
      pix_mag = ~iPIXEL + 12'd1;
    else
      pix_mag = iPIXEL;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (iDVAL) begin
      if (col_wrap) begin
        col <= '0;
        row <= row_wrap ? '0 : cur_row + 1'b1;
      end else begin
        col <= cur_col + 1'b1;
        row <= cur_row;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid     <= 1'b0;
      s1_mag       <= '0;
      s1_mask      <= 1'b0;
      s1_last      <= 1'b0;
      s1_start     <= 1'b0;
      s1_thresh    <= '0;
      s1_thresh_en <= 1'b0;
    end else begin
      s1_valid <= iDVAL;
      if (iDVAL) begin
        s1_mag       <= pix_mag;
        s1_mask      <= pix_mask;
        s1_last      <= pix_last;
        s1_start     <= iFRAME_START;
        s1_thresh    <= iTHRESH;
        s1_thresh_en <= iTHRESH_EN;
      end
    end
  end

  // The count restarts when the frame-start pixel reaches stage 2, so older
  // pixels still in flight are not charged to the new frame.
  always_comb begin
    s1_edge  = !s1_mask && (s1_mag >= s1_thresh);
    if (s1_mask)
      s1_out = '0;
    else if (s1_thresh_en)
      s1_out = s1_edge ? 12'hFFF : 12'h000;
    else
      s1_out = s1_mag;
    run_base = s1_start ? '0 : run_count;
    if (s1_edge && run_base != '1)
      run_next = run_base + 1'b1;
    else
      run_next = run_base;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      oDVAL       <= 1'b0;
      oFRAME_DONE <= 1'b0;
      oEDGE_COUNT <= '0;
      rgb         <= '0;
      run_count   <= '0;
    end else begin
      oDVAL <= s1_valid;
      if (s1_valid) begin
        rgb         <= s1_out;
        oFRAME_DONE <= s1_last;
        if (s1_last) begin
          oEDGE_COUNT <= run_next;
          run_count   <= '0;
        end else begin
          run_count   <= run_next;
        end
      end else begin
        oFRAME_DONE <= 1'b0;
      end
    end
  end

  assign oRED   = rgb;
  assign oGREEN = rgb;
  assign oBLUE  = rgb;

endmodule
